// File: rtl/pe_pkg.sv
// pe_pkg: shared defaults, loader state encoding and frame size for the PE data path
package pe_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_L_RAM_SIZE = 4;
  localparam int DEF_VECTOR_SIZE = 1 << DEF_L_RAM_SIZE;
  localparam int FRAME_WORDS = 2 * DEF_VECTOR_SIZE;
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2
  } ld_state_t;
endpackage

// File: rtl/pe_din_loader_if.sv
// pe_din_loader_if: valid/ready word stream carrying one frame of operand words
interface pe_din_loader_if #(
  parameter int DATA_W = pe_pkg::DEF_DATA_W
) ();
  logic              valid;
  logic              ready;
  logic              last;
  logic [DATA_W-1:0] data;
  modport master (output valid, data, last, input ready);
  modport slave (input valid, data, last, output ready);
endinterface

// File: rtl/pe_frame_ram.sv
// pe_frame_ram: simple dual-port frame buffer with one write port and a registered read port
module pe_frame_ram #(
  parameter int AW = pe_pkg::DEF_L_RAM_SIZE + 1,
  parameter int DW = pe_pkg::DEF_DATA_W
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  // storage write; contents survive reset
  always_ff @(posedge aclk)
    if (we) mem[waddr] <= wdata;
  // registered read, cleared only on reset
  always_ff @(posedge aclk)
    rdata <= areset ? '0 : mem[raddr];
endmodule

// File: rtl/pe_din_loader.sv
// pe_din_loader: packs a stream frame into a buffer, starts the PE and serves its reads
module pe_din_loader
  import pe_pkg::*;
#(
  parameter int L_RAM_SIZE  = DEF_L_RAM_SIZE,
  parameter int VECTOR_SIZE = DEF_VECTOR_SIZE,
  parameter int DATA_W      = DEF_DATA_W
) (
  input  logic                  aclk,
  input  logic                  areset,
  pe_din_loader_if.slave        s,
  output logic                  pe_start,
  input  logic                  pe_done,
  input  logic [L_RAM_SIZE:0]   pe_rdaddr,
  output logic [DATA_W-1:0]     pe_rddata,
  output logic                  busy,
  output logic                  err_len,
  output logic [15:0]           frame_cnt
);
  localparam logic [L_RAM_SIZE:0] LAST_IDX = (L_RAM_SIZE + 1)'(2 * VECTOR_SIZE - 1);
  ld_state_t           state;
  logic [L_RAM_SIZE:0] wr_ptr;
  logic                wr_en;
  assign wr_en = s.valid && s.ready;
  // frame fill, start pulse and run/done handshake with registered outputs
  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= FILL;
      wr_ptr    <= '0;
      s.ready   <= 1'b0;
      pe_start  <= 1'b0;
      busy      <= 1'b0;
      err_len   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      pe_start <= 1'b0;
      err_len  <= 1'b0;
      case (state)
        FILL: begin
          s.ready <= 1'b1;
          if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_IDX) begin
              state    <= START;
              s.ready  <= 1'b0;
              pe_start <= 1'b1;
              err_len  <= !s.last;
            end else if (s.last) begin
              wr_ptr  <= '0;
              err_len <= 1'b1;
            end
          end
        end
        START: begin
          busy  <= 1'b1;
          state <= RUN;
        end
        RUN: begin
          if (pe_done) begin
            busy      <= 1'b0;
            frame_cnt <= frame_cnt + 16'd1;
            wr_ptr    <= '0;
            state     <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
  pe_frame_ram #(.AW(L_RAM_SIZE + 1), .DW(DATA_W)) u_ram (
    .aclk  (aclk),
    .areset(areset),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (s.data),
    .raddr (pe_rdaddr),
    .rdata (pe_rddata)
  );
endmodule

// File: tb/tb_pe_din_loader.sv
// tb_pe_din_loader: table-driven frame vectors with a readback scoreboard plus reset/done corner cases
module tb_pe_din_loader;
  logic        aclk = 1'b0;
  logic        areset;
  logic        pe_start, pe_done, busy, err_len;
  logic [4:0]  pe_rdaddr;
  logic [31:0] pe_rddata;
  logic [15:0] frame_cnt;
  int          n_chk = 0, n_fail = 0;
  int          start_cnt = 0, err_cnt = 0;
  int          fc = 0;
  logic [31:0] exp_q [$];
  pe_din_loader_if #(.DATA_W(32)) s_if ();
  pe_din_loader dut (
    .aclk     (aclk),
    .areset   (areset),
    .s        (s_if),
    .pe_start (pe_start),
    .pe_done  (pe_done),
    .pe_rdaddr(pe_rdaddr),
    .pe_rddata(pe_rddata),
    .busy     (busy),
    .err_len  (err_len),
    .frame_cnt(frame_cnt)
  );
  always #5 aclk = ~aclk;
  always @(posedge aclk) begin
    if (pe_start) start_cnt <= start_cnt + 1;
    if (err_len) err_cnt <= err_cnt + 1;
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  typedef struct {
    string       nm;
    int          n;
    int          last_pos;
    bit          bub;
    logic [31:0] base;
    bit          exp_start;
    bit          exp_err;
  } vec_t;
  vec_t tbl [5];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic send_frame(input int n, input int last_pos, input bit bub, input logic [31:0] base);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 2000) begin
      @(negedge aclk);
      guard++;
      s_if.valid = bub ? 1'($urandom_range(0, 1)) : 1'b1;
      s_if.data  = base + 32'(i);
      s_if.last  = (i == last_pos);
      if (s_if.valid && s_if.ready) begin
        exp_q.push_back(base + 32'(i));
        i++;
      end
    end
    if (i < n) chk("send_timeout", 32'(i), 32'(n));
    @(negedge aclk);
    s_if.valid = 1'b0;
    s_if.last  = 1'b0;
  endtask
  task automatic readout(input string nm);
    for (int k = 0; k < 32; k++) begin
      @(negedge aclk);
      pe_rdaddr = 5'(k);
      @(negedge aclk);
      if (exp_q.size() == 0) chk({nm, "_sb_empty"}, 32'(k), 32'd32);
      else chk({nm, "_rd"}, pe_rddata, exp_q.pop_front());
    end
  endtask
  task automatic finish_frame(input string nm);
    @(negedge aclk);
    pe_done = 1'b1;
    @(negedge aclk);
    pe_done = 1'b0;
    fc++;
    chk({nm, "_busy_done"}, busy, 0);
    chk({nm, "_frame_cnt"}, frame_cnt, fc);
    chk({nm, "_ready_done"}, s_if.ready, 0);
    @(negedge aclk);
    chk({nm, "_ready_rearm"}, s_if.ready, 1);
  endtask
  task automatic check_reset(input string nm);
    chk({nm, "_ready"}, s_if.ready, 0);
    chk({nm, "_start"}, pe_start, 0);
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err_len, 0);
    chk({nm, "_rddata"}, pe_rddata, 0);
    chk({nm, "_frame_cnt"}, frame_cnt, 0);
  endtask
  task automatic run_vec(input vec_t v);
    int s0, e0;
    s0 = start_cnt;
    e0 = err_cnt;
    exp_q.delete();
    send_frame(v.n, v.last_pos, v.bub, v.base);
    chk({v.nm, "_start_pulse"}, pe_start, v.exp_start);
    chk({v.nm, "_err_pulse"}, err_len, v.exp_err);
    @(negedge aclk);
    chk({v.nm, "_start_low"}, pe_start, 0);
    chk({v.nm, "_busy"}, busy, v.exp_start);
    chk({v.nm, "_ready"}, s_if.ready, !v.exp_start);
    repeat (2) @(negedge aclk);
    chk({v.nm, "_start_count"}, start_cnt - s0, v.exp_start);
    chk({v.nm, "_err_count"}, err_cnt - e0, v.exp_err);
    if (v.exp_start) begin
      readout(v.nm);
      finish_frame(v.nm);
    end else exp_q.delete();
  endtask
  initial begin
    int s0;
    tbl[0] = '{"nominal",  32, 31, 1'b0, 32'h3F80_0000, 1'b1, 1'b0};
    tbl[1] = '{"short",    10,  9, 1'b0, 32'h4000_0000, 1'b0, 1'b1};
    tbl[2] = '{"post_short", 32, 31, 1'b0, 32'h4040_0000, 1'b1, 1'b0};
    tbl[3] = '{"bubbles",  32, 31, 1'b1, 32'h3F80_0000, 1'b1, 1'b0};
    tbl[4] = '{"no_last",  32, -1, 1'b0, 32'h4080_0000, 1'b1, 1'b1};
    areset = 1'b1;
    pe_done = 1'b0;
    pe_rdaddr = '0;
    s_if.valid = 1'b0;
    s_if.last = 1'b0;
    s_if.data = '0;
    repeat (2) @(negedge aclk);
    check_reset("reset");
    areset = 1'b0;
    @(negedge aclk);
    chk("ready_after_reset", s_if.ready, 1);
    for (int t = 0; t < 5; t++) run_vec(tbl[t]);
    pe_done = 1'b1;
    repeat (3) @(negedge aclk);
    chk("spur_fill_frame_cnt", frame_cnt, fc);
    chk("spur_fill_busy", busy, 0);
    pe_done = 1'b0;
    exp_q.delete();
    send_frame(32, 31, 1'b0, 32'h4100_0000);
    chk("spur_start_pulse", pe_start, 1);
    pe_done = 1'b1;
    @(negedge aclk);
    pe_done = 1'b0;
    chk("spur_start_busy", busy, 1);
    chk("spur_start_frame_cnt", frame_cnt, fc);
    repeat (3) @(negedge aclk);
    chk("spur_start_busy_held", busy, 1);
    readout("spur");
    finish_frame("spur");
    s0 = start_cnt;
    exp_q.delete();
    send_frame(20, -1, 1'b0, 32'h4200_0000);
    areset = 1'b1;
    @(negedge aclk);
    check_reset("rst_fill");
    areset = 1'b0;
    fc = 0;
    repeat (3) @(negedge aclk);
    chk("rst_fill_no_start", start_cnt - s0, 0);
    exp_q.delete();
    send_frame(32, 31, 1'b0, 32'h4300_0000);
    repeat (2) @(negedge aclk);
    chk("rst_run_busy_before", busy, 1);
    areset = 1'b1;
    @(negedge aclk);
    check_reset("rst_run");
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_run_ready", s_if.ready, 1);
    run_vec(tbl[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_din_loader.md
Name: pe_din_loader

Overview:
- Upstream feeder for the PE controller (pe_con).
- Accepts a valid/ready word stream and packs one frame of 2*VECTOR_SIZE 32-bit words into a local buffer.
- Pulses start to the controller, then serves its read port with 1-cycle latency until it reports done.
- Then re-arms for the next frame. Each frame is the vector pair (A then B) the PE consumes.

Parameters:
- L_RAM_SIZE, 4, log2 of VECTOR_SIZE; buffer depth is 2**(L_RAM_SIZE+1).
- VECTOR_SIZE, 16, words per operand vector; must equal 2**L_RAM_SIZE.
- DATA_W, 32, word width.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  synchronous, active-high reset.
- s_valid  in  1  upstream word valid.
- s_data  in  DATA_W  upstream word.
- s_last  in  1  marks final word of a frame.
- s_ready  out  1  loader can accept a word.
- pe_start  out  1  one-cycle start pulse to the PE controller.
- pe_done  in  1  PE controller finished the frame.
- pe_rdaddr  in  L_RAM_SIZE+1  PE read address.
- pe_rddata  out  DATA_W  buffer word; registered, 1-cycle read latency.
- busy  out  1  high from start pulse until done accepted.
- err_len  out  1  one-cycle pulse on frame length error.
- frame_cnt  out  16  completed frames, wraps at 65535 -> 0.

Behaviour:
- Interface: one clock aclk; reset areset is synchronous and active-high.
- Reset values: s_ready=0, pe_start=0, busy=0, err_len=0, pe_rddata=0, frame_cnt=0, wr_ptr=0, state=FILL. Buffer contents are not cleared.
- Transfer: a word is written when s_valid && s_ready, to buf[wr_ptr], then wr_ptr++.
- FSM FILL: s_ready=1 (from the first cycle after reset deasserts).
  - Accepted word with wr_ptr<2*VS-1 and s_last=1: short frame. Pulse err_len next cycle, wr_ptr<=0, discard the frame, stay in FILL.
  - Accepted word with wr_ptr==2*VS-1: go to START, s_ready<=0. If s_last=0 on this word, pulse err_len (missing last) but still proceed.
- FSM START: pe_start=1 for exactly one cycle, busy<=1, go to RUN.
  - The pulse occurs the cycle after the last write is registered, so the last word is readable on the start cycle.
- FSM RUN: s_ready=0; buffer writes impossible.
  - On pe_done=1: busy<=0, frame_cnt++, wr_ptr<=0, go to FILL. s_ready=1 the following cycle.
- Read port:
  - pe_rddata <= buf[pe_rdaddr] every cycle in every state (address registered at edge N, data valid after edge N+1).
  - Reads in FILL return stale or partial data; the consumer must not rely on them.
- Write/read collision: unreachable, since writes only occur in FILL and valid reads only in RUN.
- pe_done outside RUN is ignored.
- pe_done in the same cycle as the START pulse is ignored; it is honoured from the first RUN cycle.
- areset asserted in any state, mid-frame or mid-RUN: all state returns to reset values next edge. A partial frame is discarded. No pe_start is issued for it.
- Throughput: 2*VS cycles minimum fill (s_valid held high), +1 START, + PE run time, +1 re-arm cycle.

Decomposition:
- Shared package pe_pkg:
  - DATA_W, L_RAM_SIZE defaults.
  - Loader state encoding (FILL, START, RUN).
  - Constant FRAME_WORDS = 2*VECTOR_SIZE.
- One sub-module: pe_frame_ram. Simple dual-port, one write port plus one registered read port, depth 2**(L_RAM_SIZE+1), DATA_W wide, inferable as block RAM. The FSM and pointer stay in the top level.

Test Plan:
- Nominal frame: after reset, stream words 0x3F800000+i for i=0..31 back-to-back with s_last on i=31.
  - Required: pe_start pulses exactly once, one cycle after the 32nd handshake; s_ready=0 and busy=1 afterwards.
  - Required: reading pe_rdaddr=k returns 0x3F800000+k one cycle later.
  - Drive pe_done: busy=0 and frame_cnt=1; s_ready=1 the next cycle.
- Backpressure/bubbles: toggle s_valid randomly (~50%) across 32 words.
  - Required: buffer contents identical to nominal; pe_start only after the 32nd accepted word.
- Short frame: s_last on word 9.
  - Required: err_len pulses once, no pe_start.
  - A following correct 32-word frame loads from address 0 and starts normally.
- Missing last: 32 words with s_last=0.
  - Required: err_len pulse, pe_start still issued, frame_cnt increments after pe_done.
- Reset mid-operation: areset for 1 cycle after 20 words; second run asserts it during RUN.
  - Required: all outputs return to reset values next edge, no pe_start, frame_cnt=0.
  - A fresh 32-word frame then completes correctly.
- Spurious done: pulse pe_done during FILL and on the START cycle.
  - Required: ignored; frame_cnt unchanged and busy stays high until a pe_done in RUN.
